// File: rtl/fp_issue.sv
// Issue controller between decode and the FP execute unit: accepts one instruction,
// pulses it into the execute unit, watches busy with a watchdog and hands the result to writeback.
module fp_issue #(
    parameter int REGFILE_WIDTH = 32,
    parameter int RD_W          = 3,
    parameter int MAX_WAIT      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REGFILE_WIDTH-1:0] in_reg1,
    input  logic [REGFILE_WIDTH-1:0] in_reg2,
    input  logic [REGFILE_WIDTH-1:0] in_imm,
    input  logic [REGFILE_WIDTH-1:0] in_pc_inc,
    input  logic [3:0]               in_aluop,
    input  logic [1:0]               in_instfmt,
    input  logic                     in_alusrc,
    input  logic [RD_W-1:0]          in_rd,
    input  logic                     flush,
    output logic                     fp_inst_valid,
    output logic [REGFILE_WIDTH-1:0] reg1,
    output logic [REGFILE_WIDTH-1:0] reg2,
    output logic [REGFILE_WIDTH-1:0] imm,
    output logic [REGFILE_WIDTH-1:0] pc_inc,
    output logic [3:0]               AluOp,
    output logic [1:0]               InstFmt,
    output logic                     AluSrc,
    input  logic                     busy,
    input  logic [REGFILE_WIDTH-1:0] alu_out,
    input  logic                     ex_err,
    output logic                     wb_valid,
    output logic [RD_W-1:0]          wb_rd,
    output logic [REGFILE_WIDTH-1:0] wb_data,
    output logic                     wb_err,
    output logic                     wb_timeout,
    output logic                     stall
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        WB
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wcnt;
    logic              kill;
    logic              err_q;
    logic              timeout_q;
    logic              accept;
    logic              capture;
    logic              expire;

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        fp_inst_valid = 1'b0;
        wb_valid      = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        expire        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~busy & ~flush & ~rst;
                accept   = in_valid & ~busy & ~flush & ~rst;
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                fp_inst_valid = ~rst;
                state_next    = WAIT_START;
            end
            WAIT_START: begin
                // A unit that starts on the last allowed cycle still counts as started.
                if (busy) begin
                    state_next = WAIT_DONE;
                end else if (wcnt == WCNT_MAX) begin
                    expire     = 1'b1;
                    state_next = WB;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    capture    = 1'b1;
                    state_next = WB;
                end else if (wcnt == WCNT_MAX) begin
                    expire     = 1'b1;
                    state_next = WB;
                end
            end
            WB: begin
                wb_valid   = ~kill & ~flush & ~rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall      = ~rst & ((state != IDLE) | (in_valid & ~in_ready));
    assign wb_err     = err_q | timeout_q;
    assign wb_timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            kill      <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            reg1      <= '0;
            reg2      <= '0;
            imm       <= '0;
            pc_inc    <= '0;
            AluOp     <= '0;
            InstFmt   <= '0;
            AluSrc    <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                reg1      <= in_reg1;
                reg2      <= in_reg2;
                imm       <= in_imm;
                pc_inc    <= in_pc_inc;
                AluOp     <= in_aluop;
                InstFmt   <= in_instfmt;
                AluSrc    <= in_alusrc;
                wb_rd     <= in_rd;
                kill      <= 1'b0;
                err_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (state == ISSUE) begin
                wcnt <= '0;
            end else if ((state == WAIT_START || state == WAIT_DONE) && wcnt != WCNT_MAX) begin
                wcnt <= wcnt + 1'b1;
            end
            // The execute unit cannot be aborted, so a flush only marks the result as dead.
            if (flush && (state == ISSUE || state == WAIT_START || state == WAIT_DONE)) begin
                kill <= 1'b1;
            end
            if (capture) begin
                wb_data <= alu_out;
                err_q   <= ex_err;
            end
            if (expire) begin
                timeout_q <= 1'b1;
                wb_data   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_issue.sv
// Self-checking bench for fp_issue: a small execute-unit model drives busy, and the expected
// writeback cycle and contents are computed per instruction from the timing rules.
module tb_fp_issue;

    localparam int W            = 32;
    localparam int RDW          = 3;
    localparam int MAXW         = 16;
    localparam int FLUSH_NONE   = -1;
    localparam int FLUSH_RANDOM = -2;

    typedef struct {
        logic [W-1:0]   r1;
        logic [W-1:0]   r2;
        logic [W-1:0]   im;
        logic [W-1:0]   pc;
        logic [3:0]     op;
        logic [1:0]     fmt;
        logic           src;
        logic [RDW-1:0] rd;
    } inst_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_reg1 = '0, in_reg2 = '0, in_imm = '0, in_pc_inc = '0;
    logic [3:0]     in_aluop = '0;
    logic [1:0]     in_instfmt = '0;
    logic           in_alusrc = 1'b0;
    logic [RDW-1:0] in_rd = '0;
    logic           flush = 1'b0;
    logic           fp_inst_valid;
    logic [W-1:0]   reg1, reg2, imm, pc_inc;
    logic [3:0]     AluOp;
    logic [1:0]     InstFmt;
    logic           AluSrc;
    logic           busy = 1'b0;
    logic [W-1:0]   alu_out = '0;
    logic           ex_err = 1'b0;
    logic           wb_valid;
    logic [RDW-1:0] wb_rd;
    logic [W-1:0]   wb_data;
    logic           wb_err;
    logic           wb_timeout;
    logic           stall;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_issue #(
        .REGFILE_WIDTH(W),
        .RD_W         (RDW),
        .MAX_WAIT     (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg1      (in_reg1),
        .in_reg2      (in_reg2),
        .in_imm       (in_imm),
        .in_pc_inc    (in_pc_inc),
        .in_aluop     (in_aluop),
        .in_instfmt   (in_instfmt),
        .in_alusrc    (in_alusrc),
        .in_rd        (in_rd),
        .flush        (flush),
        .fp_inst_valid(fp_inst_valid),
        .reg1         (reg1),
        .reg2         (reg2),
        .imm          (imm),
        .pc_inc       (pc_inc),
        .AluOp        (AluOp),
        .InstFmt      (InstFmt),
        .AluSrc       (AluSrc),
        .busy         (busy),
        .alu_out      (alu_out),
        .ex_err       (ex_err),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_err       (wb_err),
        .wb_timeout   (wb_timeout),
        .stall        (stall)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic inst_t randInst();
        inst_t t;
        t.r1  = $urandom;
        t.r2  = $urandom;
        t.im  = $urandom;
        t.pc  = $urandom;
        t.op  = 4'($urandom);
        t.fmt = 2'($urandom);
        t.src = 1'($urandom);
        t.rd  = RDW'($urandom);
        return t;
    endfunction

    // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
    task automatic applyStimulus(input bit r, input bit v, input bit b, input bit f,
                                 input inst_t d, input logic [W-1:0] aluOut, input bit exErr);
        @(posedge clk);
        #1;
        rst        = r;
        in_valid   = v;
        busy       = b;
        flush      = f;
        in_reg1    = d.r1;
        in_reg2    = d.r2;
        in_imm     = d.im;
        in_pc_inc  = d.pc;
        in_aluop   = d.op;
        in_instfmt = d.fmt;
        in_alusrc  = d.src;
        in_rd      = d.rd;
        alu_out    = aluOut;
        ex_err     = exErr;
        @(negedge clk);
    endtask

    // One instruction, accepted at relative cycle 0. Busy is high over cycles [1+s, 1+s+len).
    // The watchdog deadline is cycle 2+MAXW; a unit that went busy on time is still given its
    // first WAIT_DONE cycle even if that falls past the deadline.
    task automatic runOp(input inst_t in, input int s, input int len, input bit err,
                         input logic [W-1:0] res, input int flushSel, input bit hold);
        int     h, l, dl, lim, wbc, flushAt;
        bit     tmo, killed;
        inst_t  drv;
        logic [W-1:0] aluDrv;
        bit     errDrv;
        h  = 1 + s;
        l  = h + len;
        dl = 2 + MAXW;
        if (h > dl) begin
            tmo = 1'b1;
            wbc = dl + 1;
        end else begin
            lim = (h + 1 > dl) ? h + 1 : dl;
            if (l <= lim) begin
                tmo = 1'b0;
                wbc = l + 1;
            end else begin
                tmo = 1'b1;
                wbc = lim + 1;
            end
        end
        flushAt = (flushSel == FLUSH_RANDOM) ? int'($urandom_range(1, wbc)) : flushSel;
        killed  = (flushAt >= 1) && (flushAt <= wbc);
        for (int k = 0; k <= wbc; k++) begin
            if (k == 0) drv = in;
            else        drv = randInst();
            aluDrv = (k == l) ? res : W'($urandom);
            errDrv = (k == l) ? err : 1'($urandom);
            applyStimulus(1'b0, (k == 0) || hold, (k >= h) && (k < l), (k == flushAt), drv, aluDrv, errDrv);
            checkOutput("in_ready", in_ready, k == 0);
            checkOutput("fp_inst_valid", fp_inst_valid, k == 1);
            checkOutput("stall", stall, k != 0);
            checkOutput("wb_valid", wb_valid, (k == wbc) && !killed);
            if (k >= 1) begin
                checkOutput("operands", {reg1, reg2, imm, pc_inc}, {in.r1, in.r2, in.im, in.pc});
                checkOutput("control", {AluOp, InstFmt, AluSrc, wb_rd}, {in.op, in.fmt, in.src, in.rd});
            end
            if (k == wbc && !killed) begin
                checkOutput("wb_data", wb_data, tmo ? {W{1'b0}} : res);
                checkOutput("wb_err", wb_err, tmo | err);
                checkOutput("wb_timeout", wb_timeout, tmo);
            end
        end
    endtask

    // Busy already high or a flush in IDLE must block the accept.
    task automatic idleBoundary();
        inst_t a;
        a = randInst();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, '0, 1'b0);
        checkOutput("idle_busy_ready", in_ready, 1'b0);
        checkOutput("idle_busy_stall", stall, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, '0, 1'b0);
        checkOutput("idle_flush_ready", in_ready, 1'b0);
        checkOutput("idle_flush_stall", stall, 1'b1);
        checkOutput("idle_busy_no_issue", fp_inst_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, a, '0, 1'b0);
        checkOutput("idle_flush_no_issue", fp_inst_valid, 1'b0);
        checkOutput("idle_quiet_stall", stall, 1'b0);
        checkOutput("idle_quiet_ready", in_ready, 1'b1);
    endtask

    // Reset while waiting for the unit to finish: everything clears and no writeback follows.
    task automatic resetMidOp();
        inst_t a;
        a = randInst();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, a, '0, 1'b0);
        checkOutput("rstop_accept", in_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randInst(), '0, 1'b0);
        checkOutput("rstop_issue", fp_inst_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randInst(), '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randInst(), '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, randInst(), '0, 1'b0);
        checkOutput("rstop_ready_in_reset", in_ready, 1'b0);
        checkOutput("rstop_wb_in_reset", wb_valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randInst(), 32'h1234_5678, 1'b1);
        checkOutput("rstop_flags", {in_ready, fp_inst_valid, wb_valid, wb_err, wb_timeout, stall}, 6'b0);
        checkOutput("rstop_operands", {reg1, reg2, imm, pc_inc}, 128'b0);
        checkOutput("rstop_control", {AluOp, InstFmt, AluSrc, wb_rd}, 10'b0);
        checkOutput("rstop_wb_data", wb_data, 32'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randInst(), 32'h1234_5678, 1'b1);
            checkOutput("rstop_no_wb", wb_valid, 1'b0);
            checkOutput("rstop_no_issue", fp_inst_valid, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        inst_t a;
        int    s, len;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randInst(), '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, randInst(), '0, 1'b0);
        checkOutput("reset_flags", {in_ready, fp_inst_valid, wb_valid, wb_err, wb_timeout, stall}, 6'b0);
        checkOutput("reset_operands", {reg1, reg2, imm, pc_inc}, 128'b0);
        checkOutput("reset_control", {AluOp, InstFmt, AluSrc, wb_rd}, 10'b0);
        checkOutput("reset_wb_data", wb_data, 32'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randInst(), '0, 1'b0);
        checkOutput("post_reset_ready", in_ready, 1'b1);

        a = randInst();
        a.r1 = 32'h3F80_0000;
        a.r2 = 32'h4000_0000;
        a.rd = 3'd5;
        a.op = 4'h1;
        runOp(a, 1, 2, 1'b0, 32'h4040_0000, FLUSH_NONE, 1'b0);
        runOp(randInst(), 1, 1, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 2, 3, 1'b1, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 100, 1, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 17, 1, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 17, 2, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 4, 13, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 4, 14, 1'b1, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 1, 4, 1'b0, $urandom, 3, 1'b0);
        runOp(randInst(), 1, 2, 1'b0, $urandom, FLUSH_NONE, 1'b0);
        runOp(randInst(), 1, 1, 1'b0, $urandom, 4, 1'b0);
        runOp(randInst(), 2, 3, 1'b0, $urandom, FLUSH_NONE, 1'b1);
        runOp(randInst(), 1, 2, 1'b0, $urandom, FLUSH_NONE, 1'b1);
        idleBoundary();
        resetMidOp();

        for (int n = 0; n < 40; n++) begin
            s   = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, MAXW + 4));
            len = int'($urandom_range(1, 5));
            runOp(randInst(), s, len, 1'($urandom), $urandom,
                  ($urandom_range(0, 4) == 0) ? FLUSH_RANDOM : FLUSH_NONE, 1'($urandom));
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randInst(), '0, 1'b0);
        checkOutput("final_idle_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
